seq_detect_pmod: RTL

SEQ_DETECT_PMOD -- requirements
Module: seq_detect_pmod

---
 rtl/seq_detect_pmod.sv | 126 ++++++++++++
 1 files changed

// File: rtl/seq_detect_pmod.sv
// seq_detect_pmod: debounced button-sequence detector with chord rejection, idle timeout and sticky unlock flag
module seq_detect_pmod #(
  parameter int num_symbols_p = 7,
  parameter int seq_len_p = 11,
  parameter logic [seq_len_p*$clog2(num_symbols_p)-1:0] seq_p =
    {3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd3, 3'd2, 3'd1, 3'd1, 3'd0, 3'd0},
  parameter int debounce_cycles_p = 120000,
  parameter int timeout_cycles_p = 24000000
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic [num_symbols_p-1:0]           symbol_raw_i,
  input  logic                               clear_i,
  output logic                               symbol_valid_o,
  output logic [$clog2(num_symbols_p)-1:0]   symbol_o,
  output logic                               chord_o,
  output logic [$clog2(seq_len_p+1)-1:0]     progress_o,
  output logic                               match_o,
  output logic                               unlocked_o
);
  localparam int sym_w = $clog2(num_symbols_p);
  localparam int prog_w = $clog2(seq_len_p + 1);
  localparam int dw = $clog2(debounce_cycles_p + 1);
  localparam int tw = timeout_cycles_p > 1 ? $clog2(timeout_cycles_p + 1) : 1;
  localparam logic [dw-1:0] dlim = dw'(debounce_cycles_p - 1);
  localparam logic [tw-1:0] tlim = tw'(timeout_cycles_p - 1);
  localparam logic [prog_w-1:0] plen = prog_w'(seq_len_p);

  typedef enum logic [1:0] {IDLE, TRACK, MATCH} state_t;

  logic [num_symbols_p-1:0] s1, s2, deb, deb_n, falls;
  logic [dw-1:0] cnt [num_symbols_p];
  logic [dw-1:0] cnt_n [num_symbols_p];
  logic chord_q, chord_n, multi, ev_chord_n;
  logic ev_valid, ev_chord;
  logic [sym_w-1:0] ev_sym, sym_n;
  state_t state, state_n;
  logic [prog_w-1:0] prog, prog_n, base;
  logic [tw-1:0] tcnt, tcnt_n;
  logic unlocked, hit, first, to;
  logic [sym_w-1:0] seq_a [2**prog_w];

  // Unpack the target sequence; entries past the end are never indexed but keep the table full-width
  for (genvar i = 0; i < 2**prog_w; i++) begin : g_seq
    if (i < seq_len_p) begin : g_v
      assign seq_a[i] = seq_p[i*sym_w +: sym_w];
    end else begin : g_z
      assign seq_a[i] = '0;
    end
  end

  // Debounce: count mismatch cycles, flip the level when the count reaches the limit
  always_comb begin
    deb_n = deb;
    for (int i = 0; i < num_symbols_p; i++) begin
      cnt_n[i] = (s2[i] == deb[i] || cnt[i] == dlim) ? '0 : cnt[i] + 1'b1;
      deb_n[i] = (s2[i] != deb[i] && cnt[i] == dlim) ? ~deb[i] : deb[i];
    end
  end

  // Event decode: releases produce events, lowest falling channel wins, overlaps mark a chord
  always_comb begin
    falls = deb & ~deb_n;
    sym_n = '0;
    for (int i = num_symbols_p - 1; i >= 0; i--) sym_n = falls[i] ? sym_w'(i) : sym_n;
    multi = |(deb & (deb - 1'b1));
    chord_n = |falls ? 1'b0 : (chord_q | multi);
    ev_chord_n = |falls & (chord_q | multi | |(falls & (falls - 1'b1)) | |deb_n);
  end

  // Synchronisers, debounced levels, chord flag and the registered symbol event
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      s1 <= '0;
      s2 <= '0;
      deb <= '0;
      for (int i = 0; i < num_symbols_p; i++) cnt[i] <= '0;
      chord_q <= 1'b0;
      ev_valid <= 1'b0;
      ev_sym <= '0;
      ev_chord <= 1'b0;
    end else begin
      s1 <= symbol_raw_i;
      s2 <= s1;
      deb <= deb_n;
      for (int i = 0; i < num_symbols_p; i++) cnt[i] <= cnt_n[i];
      chord_q <= chord_n;
      ev_valid <= |falls;
      ev_sym <= sym_n;
      ev_chord <= ev_chord_n;
    end
  end

  // Matcher next state: events beat the timeout, MATCH restarts from an empty prefix
  always_comb begin
    base = (state == MATCH) ? '0 : prog;
    hit = ev_valid & ~ev_chord & (ev_sym == seq_a[base]);
    first = ev_valid & ~ev_chord & (ev_sym == seq_a[0]);
    to = (timeout_cycles_p != 0) && (state == TRACK) && (tcnt == tlim);
    prog_n = ev_valid ? (hit ? base + 1'b1 : prog_w'(first)) : ((state == MATCH || to) ? '0 : prog);
    tcnt_n = (ev_valid || state != TRACK || to || timeout_cycles_p == 0) ? '0 : tcnt + 1'b1;
    state_n = (prog_n == plen) ? MATCH : ((prog_n == '0) ? IDLE : TRACK);
  end

  // Matcher state register and sticky unlock flag (clear beats a simultaneous set)
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= IDLE;
      prog <= '0;
      tcnt <= '0;
      unlocked <= 1'b0;
    end else begin
      state <= state_n;
      prog <= prog_n;
      tcnt <= tcnt_n;
      unlocked <= clear_i ? 1'b0 : (unlocked | (state == MATCH));
    end
  end

  assign symbol_valid_o = ev_valid;
  assign symbol_o = ev_sym;
  assign chord_o = ev_chord;
  assign progress_o = prog;
  assign match_o = (state == MATCH);
  assign unlocked_o = unlocked;
endmodule
